// File: rtl/fx2_stream_writer.sv
// Streams FIFO words to the FX2 slave FIFO as LS-first halfwords, committing packets on size, idle timeout or disable.
// Optional STREAM_TEST_PATTERN_EN: TEST_MODE swaps the source for an internal halfword counter.
module fx2_stream_writer #(
    parameter int         IN_WIDTH   = 32,
    parameter int         PKT_HWORDS = 256,
    parameter int         TIMEOUT    = 1024,
    parameter logic [1:0] FIFO_ADDR  = 2'b10
) (
    input  logic                STREAM_CLK,
    input  logic                STREAM_RST_N,
    input  logic                ENABLE,
    input  logic                TEST_MODE,
    output logic                FIFO_READ,
    input  logic                FIFO_EMPTY,
    input  logic [IN_WIDTH-1:0] FIFO_DATA,
    input  logic [2:0]          USB_STREAM_FLAGS_N,
    input  logic                USB_STREAM_FX2RDY,
    output logic                USB_STREAM_SLWR_n,
    output logic                USB_STREAM_PKTEND_N,
    output logic [1:0]          USB_STREAM_FIFOADDR,
    output logic                USB_STREAM_SLOE_n,
    output logic                USB_STREAM_SLRD_n,
    output logic [15:0]         USB_STREAM_DATA,
    output logic [15:0]         PKT_CNT
);
    localparam int NSUB = IN_WIDTH / 16;
    localparam int IDXW = (NSUB > 1) ? $clog2(NSUB) : 1;
    localparam int TMW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, PKTEND} state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] sreg;
    logic [IN_WIDTH-1:0] sreg_nx;
    logic [IN_WIDTH-1:0] src_word;
    logic [IDXW-1:0]     idx;
    logic [9:0]          hw_cnt;
    logic [9:0]          hw_nx;
    logic [TMW-1:0]      tmo;
    logic                not_full, test_sel, fetch, wr, tmo_hit;
    logic                unused_ok;

    assign not_full = USB_STREAM_FLAGS_N[1];
    assign unused_ok = &{1'b0, TEST_MODE, USB_STREAM_FLAGS_N[2], USB_STREAM_FLAGS_N[0]};

`ifdef STREAM_TEST_PATTERN_EN
    logic [15:0]         tcnt;
    logic [IN_WIDTH-1:0] test_word;

    assign test_sel = TEST_MODE;

    // Next NSUB counter values, lowest in the halfword sent first
    always_comb begin
        test_word = '0;
        for (int i = 0; i < NSUB; i++) test_word[16*i +: 16] = tcnt + 16'(i);
    end

    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N)  tcnt <= '0;
        else if (wr)        tcnt <= tcnt + 16'd1;
    end

    assign src_word = test_sel ? test_word : FIFO_DATA;
`else
    assign test_sel = 1'b0;
    assign src_word = FIFO_DATA;
`endif

    assign fetch = (state == IDLE) && ENABLE && USB_STREAM_FX2RDY && not_full &&
                   (test_sel || !FIFO_EMPTY);
    assign wr    = (state == SEND) && not_full;
    assign hw_nx = hw_cnt + 10'd1;
    assign sreg_nx = sreg >> 16;
    assign tmo_hit = (TIMEOUT != 0) && ((tmo + TMW'(1)) == TMW'(TIMEOUT));

    // Pop is combinational so the FWFT word is captured on the same edge; held off during reset
    assign FIFO_READ           = STREAM_RST_N && fetch && !test_sel;
    assign USB_STREAM_SLWR_n   = !wr;
    assign USB_STREAM_PKTEND_N = !((state == PKTEND) && not_full);
    assign USB_STREAM_FIFOADDR = FIFO_ADDR;
    assign USB_STREAM_SLOE_n   = 1'b1;
    assign USB_STREAM_SLRD_n   = 1'b1;

    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            state           <= IDLE;
            sreg            <= '0;
            idx             <= '0;
            hw_cnt          <= '0;
            tmo             <= '0;
            USB_STREAM_DATA <= '0;
            PKT_CNT         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch) begin
                        sreg            <= src_word;
                        USB_STREAM_DATA <= src_word[15:0];
                        idx             <= '0;
                        tmo             <= '0;
                        state           <= SEND;
                    end else if (hw_cnt != '0) begin
                        if (!ENABLE || tmo_hit) state <= PKTEND;
                        else                    tmo   <= tmo + TMW'(1);
                    end else begin
                        tmo <= '0;
                    end
                end
                SEND: begin
                    if (not_full) begin
                        hw_cnt <= hw_nx;
                        sreg   <= sreg_nx;
                        if (idx == IDXW'(NSUB - 1)) begin
                            state <= (hw_nx >= 10'(PKT_HWORDS)) ? PKTEND : IDLE;
                        end else begin
                            idx             <= idx + IDXW'(1);
                            USB_STREAM_DATA <= sreg_nx[15:0];
                        end
                    end
                end
                PKTEND: begin
                    if (not_full) begin
                        PKT_CNT <= PKT_CNT + 16'd1;
                        hw_cnt  <= '0;
                        tmo     <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fx2_stream_writer.sv
// Randomised bench for fx2_stream_writer: FIFO/FX2 models, write/PKTEND recorder and per-scenario checks.
module tb_fx2_stream_writer;
    localparam int IW  = 32;
    localparam int PKT = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          tm = 1'b0;
    logic          rdy = 1'b1;
    logic [2:0]    flags = 3'b111;
    logic          fifo_read, fifo_empty;
    logic [IW-1:0] fifo_data;
    logic          slwr_n, pktend_n, sloe_n, slrd_n;
    logic [1:0]    faddr;
    logic [15:0]   data, pkt_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int exp_pkts = 0;

    always #5 clk = ~clk;

    fx2_stream_writer #(.IN_WIDTH(IW), .PKT_HWORDS(PKT), .TIMEOUT(TMO), .FIFO_ADDR(2'b10)) dut (
        .STREAM_CLK(clk), .STREAM_RST_N(rst_n), .ENABLE(en), .TEST_MODE(tm),
        .FIFO_READ(fifo_read), .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data),
        .USB_STREAM_FLAGS_N(flags), .USB_STREAM_FX2RDY(rdy),
        .USB_STREAM_SLWR_n(slwr_n), .USB_STREAM_PKTEND_N(pktend_n),
        .USB_STREAM_FIFOADDR(faddr), .USB_STREAM_SLOE_n(sloe_n), .USB_STREAM_SLRD_n(slrd_n),
        .USB_STREAM_DATA(data), .PKT_CNT(pkt_cnt)
    );

    // First-word-fall-through source FIFO
    logic [IW-1:0] mem [0:4095];
    logic [11:0]   wr_ptr = '0;
    logic [11:0]   rd_ptr = '0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr];

    // FX2 side: record every halfword accepted and every PKTEND strobe
    int          cyc = 0, got_n = 0, pe_n = 0, viol = 0;
    logic [15:0] got [0:2047];
    int          got_cyc [0:2047];
    int          pe_wr [0:1023];
    int          pe_cyc [0:1023];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!slwr_n) begin
            got[got_n]     <= data;
            got_cyc[got_n] <= cyc;
            got_n          <= got_n + 1;
        end
        if (!pktend_n) begin
            pe_wr[pe_n]  <= got_n;
            pe_cyc[pe_n] <= cyc;
            pe_n         <= pe_n + 1;
        end
        if (fifo_read) rd_ptr <= rd_ptr + 12'd1;
        if ((fifo_read && (!slwr_n || !pktend_n || fifo_empty)) || (!slwr_n && !pktend_n))
            viol <= viol + 1;
    end

    task automatic push(input logic [IW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 12'd1;
    endtask

    task automatic wait_writes(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (got_n >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_pe(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (pe_n >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        int base, pe0;
        bit ok;
        rst_n = 1'b0; en = 1'b1; tm = 1'b0; flags = 3'b111; rdy = 1'b1;
        push(32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        n_chk++; if (slwr_n !== 1'b1)    $display("FAIL reset_slwr: got %b exp 1", slwr_n); else n_pass++;
        n_chk++; if (pktend_n !== 1'b1)  $display("FAIL reset_pktend: got %b exp 1", pktend_n); else n_pass++;
        n_chk++; if (fifo_read !== 1'b0) $display("FAIL reset_fifo_read: got %b exp 0", fifo_read); else n_pass++;
        n_chk++; if (data !== 16'h0)     $display("FAIL reset_data: got %h exp 0000", data); else n_pass++;
        n_chk++; if (pkt_cnt !== 16'h0)  $display("FAIL reset_pkt_cnt: got %h exp 0000", pkt_cnt); else n_pass++;
        n_chk++; if (faddr !== 2'b10)    $display("FAIL fifoaddr: got %b exp 10", faddr); else n_pass++;
        n_chk++; if (sloe_n !== 1'b1)    $display("FAIL sloe: got %b exp 1", sloe_n); else n_pass++;
        n_chk++; if (slrd_n !== 1'b1)    $display("FAIL slrd: got %b exp 1", slrd_n); else n_pass++;
        base = got_n; pe0 = pe_n;
        rst_n = 1'b1;
        wait_pe(pe0 + 1, 80, ok);
        n_chk++; if (!ok) $display("FAIL reset_first_pkt: no PKTEND within 80 cycles"); else n_pass++;
        n_chk++; if (got[base] !== 16'hBEEF)   $display("FAIL reset_first_lo: got %h exp BEEF", got[base]); else n_pass++;
        n_chk++; if (got[base+1] !== 16'hDEAD) $display("FAIL reset_first_hi: got %h exp DEAD", got[base+1]); else n_pass++;
        exp_pkts = 1;
        n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL reset_first_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
    endtask

    task automatic test_basic;
        int base, pe0;
        logic [11:0] rd0;
        logic [15:0] exp_hw [0:3];
        bit ok;
        exp_hw[0] = 16'h5678; exp_hw[1] = 16'h1234; exp_hw[2] = 16'h5555; exp_hw[3] = 16'hAAAA;
        base = got_n; pe0 = pe_n; rd0 = rd_ptr;
        push(32'h1234_5678);
        push(32'hAAAA_5555);
        wait_pe(pe0 + 1, 60, ok);
        repeat (2) @(negedge clk);
        n_chk++; if (!ok) $display("FAIL basic_pktend: no PKTEND within 60 cycles"); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (got[base+k] !== exp_hw[k]) $display("FAIL basic_data%0d: got %h exp %h", k, got[base+k], exp_hw[k]); else n_pass++;
        end
        n_chk++; if (got_n !== base + 4)      $display("FAIL basic_writes: got %0d exp %0d", got_n - base, 4); else n_pass++;
        n_chk++; if (rd_ptr - rd0 !== 12'd2)  $display("FAIL basic_pops: got %0d exp 2", rd_ptr - rd0); else n_pass++;
        n_chk++; if (pe_n !== pe0 + 1)        $display("FAIL basic_pe_count: got %0d exp 1", pe_n - pe0); else n_pass++;
        n_chk++; if (pe_wr[pe0] !== base + 4) $display("FAIL basic_pe_pos: got %0d exp %0d", pe_wr[pe0] - base, 4); else n_pass++;
        n_chk++; if (pe_cyc[pe0] - got_cyc[base+3] !== 1) $display("FAIL basic_pe_lat: got %0d exp 1", pe_cyc[pe0] - got_cyc[base+3]); else n_pass++;
        n_chk++; if (got_cyc[base+2] - got_cyc[base+1] !== 2) $display("FAIL basic_fetch_gap: got %0d exp 2", got_cyc[base+2] - got_cyc[base+1]); else n_pass++;
        exp_pkts++;
        n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL basic_pkt_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
    endtask

    task automatic test_timeout;
        int base, pe0;
        logic [31:0] w;
        bit ok;
        w = $urandom;
        base = got_n; pe0 = pe_n;
        push(w);
        wait_pe(pe0 + 1, 80, ok);
        n_chk++; if (!ok) $display("FAIL tmo_pktend: no PKTEND within 80 cycles"); else n_pass++;
        n_chk++; if (got_n !== base + 2)        $display("FAIL tmo_writes: got %0d exp 2", got_n - base); else n_pass++;
        n_chk++; if (got[base] !== w[15:0])     $display("FAIL tmo_lo: got %h exp %h", got[base], w[15:0]); else n_pass++;
        n_chk++; if (got[base+1] !== w[31:16])  $display("FAIL tmo_hi: got %h exp %h", got[base+1], w[31:16]); else n_pass++;
        n_chk++; if (pe_wr[pe0] !== base + 2)   $display("FAIL tmo_pe_pos: got %0d exp 2", pe_wr[pe0] - base); else n_pass++;
        n_chk++; if (pe_cyc[pe0] - got_cyc[base+1] !== TMO + 1)
            $display("FAIL tmo_delay: got %0d exp %0d", pe_cyc[pe0] - got_cyc[base+1], TMO + 1); else n_pass++;
        exp_pkts++;
        n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL tmo_pkt_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
    endtask

    task automatic test_backpressure;
        int base, pe0;
        logic [31:0] w;
        bit ok;
        w = $urandom;
        base = got_n; pe0 = pe_n;
        push(w);
        wait_writes(base + 1, 20, ok);
        n_chk++; if (!ok) $display("FAIL bp_first: no write within 20 cycles"); else n_pass++;
        flags = 3'b101;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (slwr_n !== 1'b1)    $display("FAIL bp_slwr%0d: got %b exp 1", i, slwr_n); else n_pass++;
            n_chk++; if (data !== w[31:16])  $display("FAIL bp_data%0d: got %h exp %h", i, data, w[31:16]); else n_pass++;
            @(negedge clk);
        end
        flags = 3'b111;
        wait_pe(pe0 + 1, 80, ok);
        n_chk++; if (!ok) $display("FAIL bp_pktend: no PKTEND within 80 cycles"); else n_pass++;
        n_chk++; if (got_n !== base + 2)       $display("FAIL bp_writes: got %0d exp 2", got_n - base); else n_pass++;
        n_chk++; if (got[base] !== w[15:0])    $display("FAIL bp_lo: got %h exp %h", got[base], w[15:0]); else n_pass++;
        n_chk++; if (got[base+1] !== w[31:16]) $display("FAIL bp_hi: got %h exp %h", got[base+1], w[31:16]); else n_pass++;
        n_chk++; if (got_cyc[base+1] - got_cyc[base] !== 6) $display("FAIL bp_gap: got %0d exp 6", got_cyc[base+1] - got_cyc[base]); else n_pass++;
        exp_pkts++;
        n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL bp_pkt_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
    endtask

    task automatic test_enable_flush;
        int base, pe0;
        logic [31:0] w;
        bit ok;
        w = $urandom;
        base = got_n; pe0 = pe_n;
        push(w);
        wait_writes(base + 1, 20, ok);
        n_chk++; if (!ok) $display("FAIL en_first: no write within 20 cycles"); else n_pass++;
        en = 1'b0;
        wait_pe(pe0 + 1, 10, ok);
        n_chk++; if (!ok) $display("FAIL en_flush: no PKTEND within 10 cycles of disable"); else n_pass++;
        n_chk++; if (got_n !== base + 2)       $display("FAIL en_word_done: got %0d exp 2", got_n - base); else n_pass++;
        n_chk++; if (got[base+1] !== w[31:16]) $display("FAIL en_hi: got %h exp %h", got[base+1], w[31:16]); else n_pass++;
        n_chk++; if (pe_wr[pe0] !== base + 2)  $display("FAIL en_pe_pos: got %0d exp 2", pe_wr[pe0] - base); else n_pass++;
        exp_pkts++;
        n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL en_pkt_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_random_stream;
        logic [31:0] ws [0:15];
        logic [15:0] eh;
        int n, base, pe0, npe, bad, bnd;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 9);
            base = got_n; pe0 = pe_n;
            for (int j = 0; j < n; j++) begin ws[j] = $urandom; push(ws[j]); end
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (got_n >= base + 2*n) begin ok = 1'b1; break; end
                flags[1] = ($urandom_range(0, 3) != 0);
            end
            flags = 3'b111;
            n_chk++; if (!ok) $display("FAIL rnd%0d_progress: %0d of %0d writes", it, got_n - base, 2*n); else n_pass++;
            npe = (2*n + PKT - 1) / PKT;
            wait_pe(pe0 + npe, 80, ok);
            repeat (2) @(negedge clk);
            n_chk++; if (!ok) $display("FAIL rnd%0d_pktend: %0d of %0d PKTENDs", it, pe_n - pe0, npe); else n_pass++;
            bad = 0;
            for (int k = 0; k < 2*n; k++) begin
                eh = (k % 2 == 0) ? ws[k/2][15:0] : ws[k/2][31:16];
                if (got[base+k] !== eh) bad++;
            end
            n_chk++; if (bad !== 0)            $display("FAIL rnd%0d_data: %0d wrong halfwords exp 0", it, bad); else n_pass++;
            n_chk++; if (got_n !== base + 2*n) $display("FAIL rnd%0d_writes: got %0d exp %0d", it, got_n - base, 2*n); else n_pass++;
            n_chk++; if (pe_n !== pe0 + npe)   $display("FAIL rnd%0d_pe_count: got %0d exp %0d", it, pe_n - pe0, npe); else n_pass++;
            bad = 0;
            for (int k = 0; k < npe; k++) begin
                bnd = (PKT*(k+1) < 2*n) ? PKT*(k+1) : 2*n;
                if (pe_wr[pe0+k] !== base + bnd) bad++;
            end
            n_chk++; if (bad !== 0) $display("FAIL rnd%0d_pe_pos: %0d misplaced PKTENDs exp 0", it, bad); else n_pass++;
            exp_pkts += npe;
            n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL rnd%0d_pkt_cnt: got %0d exp %0d", it, pkt_cnt, exp_pkts); else n_pass++;
        end
    endtask

    task automatic test_reset_midword;
        int base, pe0;
        logic [31:0] w;
        bit ok;
        w = $urandom;
        base = got_n; pe0 = pe_n;
        push(w);
        wait_writes(base + 1, 20, ok);
        n_chk++; if (!ok) $display("FAIL rstmid_first: no write within 20 cycles"); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (slwr_n !== 1'b1)    $display("FAIL rstmid_slwr: got %b exp 1", slwr_n); else n_pass++;
        n_chk++; if (pktend_n !== 1'b1)  $display("FAIL rstmid_pktend: got %b exp 1", pktend_n); else n_pass++;
        n_chk++; if (data !== 16'h0)     $display("FAIL rstmid_data: got %h exp 0000", data); else n_pass++;
        n_chk++; if (pkt_cnt !== 16'h0)  $display("FAIL rstmid_pkt_cnt: got %h exp 0000", pkt_cnt); else n_pass++;
        exp_pkts = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (pe_n !== pe0)       $display("FAIL rstmid_no_pktend: got %0d exp 0", pe_n - pe0); else n_pass++;
        n_chk++; if (got_n !== base + 1) $display("FAIL rstmid_dropped: got %0d exp 1", got_n - base); else n_pass++;
        w = $urandom;
        base = got_n;
        push(w);
        wait_pe(pe0 + 1, 80, ok);
        n_chk++; if (!ok) $display("FAIL rstmid_next_pkt: no PKTEND within 80 cycles"); else n_pass++;
        n_chk++; if (got[base] !== w[15:0])    $display("FAIL rstmid_next_lo: got %h exp %h", got[base], w[15:0]); else n_pass++;
        n_chk++; if (got[base+1] !== w[31:16]) $display("FAIL rstmid_next_hi: got %h exp %h", got[base+1], w[31:16]); else n_pass++;
        n_chk++; if (pe_wr[pe0] !== base + 2)  $display("FAIL rstmid_next_pos: got %0d exp 2", pe_wr[pe0] - base); else n_pass++;
        exp_pkts++;
        n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL rstmid_next_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
    endtask

    task automatic test_pattern;
        int base, pe0, bad;
        logic [11:0] rd0;
        logic [31:0] fw;
        bit ok;
        rst_n = 1'b0; tm = 1'b1; en = 1'b1;
        exp_pkts = 0;
        fw = $urandom;
        push(fw);
        repeat (2) @(negedge clk);
        base = got_n; pe0 = pe_n; rd0 = rd_ptr;
        rst_n = 1'b1;
`ifdef STREAM_TEST_PATTERN_EN
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (got_n >= base + 600) begin ok = 1'b1; break; end
        end
        en = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++; if (!ok) $display("FAIL pat_progress: %0d of 600 writes", got_n - base); else n_pass++;
        n_chk++; if (got_n !== base + 600) $display("FAIL pat_writes: got %0d exp 600", got_n - base); else n_pass++;
        bad = 0;
        for (int k = 0; k < 600; k++) if (got[base+k] !== 16'(k)) bad++;
        n_chk++; if (bad !== 0)             $display("FAIL pat_data: %0d wrong halfwords exp 0", bad); else n_pass++;
        n_chk++; if (rd_ptr !== rd0)        $display("FAIL pat_no_pop: got %0d pops exp 0", rd_ptr - rd0); else n_pass++;
        n_chk++; if (pe_n !== pe0 + 150)    $display("FAIL pat_pe_count: got %0d exp 150", pe_n - pe0); else n_pass++;
        exp_pkts += 150;
        n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL pat_pkt_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
        base = got_n; pe0 = pe_n;
        tm = 1'b0; en = 1'b1;
        wait_pe(pe0 + 1, 80, ok);
        n_chk++; if (!ok) $display("FAIL pat_fifo_after: no PKTEND within 80 cycles"); else n_pass++;
        n_chk++; if (got[base] !== fw[15:0])    $display("FAIL pat_fifo_lo: got %h exp %h", got[base], fw[15:0]); else n_pass++;
        n_chk++; if (got[base+1] !== fw[31:16]) $display("FAIL pat_fifo_hi: got %h exp %h", got[base+1], fw[31:16]); else n_pass++;
        exp_pkts++;
        n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL pat_fifo_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
`else
        begin
            logic [31:0] ws [0:3];
            logic [15:0] eh;
            ws[0] = fw;
            for (int j = 1; j < 4; j++) begin ws[j] = $urandom; push(ws[j]); end
            wait_pe(pe0 + 2, 80, ok);
            repeat (2) @(negedge clk);
            n_chk++; if (!ok) $display("FAIL nopat_pktend: %0d of 2 PKTENDs", pe_n - pe0); else n_pass++;
            bad = 0;
            for (int k = 0; k < 8; k++) begin
                eh = (k % 2 == 0) ? ws[k/2][15:0] : ws[k/2][31:16];
                if (got[base+k] !== eh) bad++;
            end
            n_chk++; if (bad !== 0)             $display("FAIL nopat_data: %0d wrong halfwords exp 0", bad); else n_pass++;
            n_chk++; if (rd_ptr - rd0 !== 12'd4) $display("FAIL nopat_pops: got %0d exp 4", rd_ptr - rd0); else n_pass++;
            exp_pkts += 2;
            n_chk++; if (pkt_cnt !== 16'(exp_pkts)) $display("FAIL nopat_pkt_cnt: got %0d exp %0d", pkt_cnt, exp_pkts); else n_pass++;
            tm = 1'b0;
        end
`endif
    endtask

    task automatic test_protocol;
        n_chk++; if (viol !== 0) $display("FAIL protocol: %0d illegal strobe cycles exp 0", viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_backpressure();
        test_enable_flush();
        test_random_stream();
        test_reset_midword();
        test_pattern();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
